// File: rtl/seq_pkg.sv
// Shared definitions for the sequence player: FSM state encoding, colour
// constants and the fixed colour tables used by seq_rom.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2,
    FIN  = 2'd3
  } state_t;

  localparam logic [3:0] RED    = 4'b0001;
  localparam logic [3:0] GREEN  = 4'b0010;
  localparam logic [3:0] BLUE   = 4'b0100;
  localparam logic [3:0] YELLOW = 4'b1000;

  localparam int TABLE_STEPS = 16;

  localparam logic [3:0] SEQ0_TABLE [TABLE_STEPS] = '{
    RED, YELLOW, BLUE, YELLOW, RED, GREEN, BLUE, YELLOW,
    RED, GREEN, YELLOW, GREEN, RED, YELLOW, BLUE, GREEN
  };

  localparam logic [3:0] SEQ1_TABLE [TABLE_STEPS] = '{
    GREEN, BLUE, RED, YELLOW, BLUE, GREEN, YELLOW, RED,
    GREEN, RED, BLUE, YELLOW, RED, BLUE, GREEN, YELLOW
  };

  // Sequences 2 and 3 are simple rotations, handy for bring-up on the board.
  localparam logic [3:0] SEQ2_TABLE [TABLE_STEPS] = '{
    RED, GREEN, BLUE, YELLOW, RED, GREEN, BLUE, YELLOW,
    RED, GREEN, BLUE, YELLOW, RED, GREEN, BLUE, YELLOW
  };

  localparam logic [3:0] SEQ3_TABLE [TABLE_STEPS] = '{
    YELLOW, BLUE, GREEN, RED, YELLOW, BLUE, GREEN, RED,
    YELLOW, BLUE, GREEN, RED, YELLOW, BLUE, GREEN, RED
  };

endpackage

// File: rtl/seq_rom.sv
// Combinational colour lookup: returns the one-hot colour for step 'address'
// of sequence 'sel'.
module seq_rom
  import seq_pkg::*;
#(
  parameter int SIZE  = 4,
  parameter int DEPTH = 16,
  parameter int NSEQ  = 4
) (
  input  logic [$clog2(NSEQ)-1:0]  sel,
  input  logic [$clog2(DEPTH)-1:0] address,
  output logic [SIZE-1:0]          colour
);

  logic [3:0] idx;
  logic [3:0] entry;

  assign idx = 4'(address);

  always_comb begin
    entry = 4'b0000;
    case (int'(sel))
      0:       entry = SEQ0_TABLE[idx];
      1:       entry = SEQ1_TABLE[idx];
      2:       entry = SEQ2_TABLE[idx];
      default: entry = SEQ3_TABLE[idx];
    endcase
  end

  assign colour = SIZE'(entry);

endmodule

// File: rtl/seq_player.sv
// Plays a stored colour sequence one step at a time: each step is shown for
// ON_TICKS cycles followed by OFF_TICKS blank cycles, then a one-cycle done.
module seq_player
  import seq_pkg::*;
#(
  parameter int SIZE      = 4,
  parameter int DEPTH     = 16,
  parameter int NSEQ      = 4,
  parameter int ON_TICKS  = 8,
  parameter int OFF_TICKS = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     stop,
  input  logic [$clog2(NSEQ)-1:0]  seq_sel,
  input  logic [$clog2(DEPTH):0]   len,
  output logic [SIZE-1:0]          saida,
  output logic [$clog2(DEPTH)-1:0] address,
  output logic                     busy,
  output logic                     done
);

  localparam int SW = $clog2(NSEQ);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TMAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int TW = $clog2(TMAX + 1);

  localparam logic [TW-1:0] ON_LAST  = TW'(ON_TICKS - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'((OFF_TICKS > 0) ? OFF_TICKS - 1 : 0);
  localparam logic [LW-1:0] LEN_MAX  = LW'(DEPTH);

  state_t        state, stateNext;
  logic [AW-1:0] addrNext;
  logic [TW-1:0] tick, tickNext;
  logic [SW-1:0] selReg, selNext;
  logic [LW-1:0] lenReg, lenNext;
  logic          lastStep;
  logic [SIZE-1:0] romColour;

  seq_rom #(
    .SIZE  (SIZE),
    .DEPTH (DEPTH),
    .NSEQ  (NSEQ)
  ) u_rom (
    .sel     (selReg),
    .address (address),
    .colour  (romColour)
  );

  // Comparing address+1 against len avoids underflow when len is zero.
  assign lastStep = (({1'b0, address} + LW'(1)) == lenReg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      address <= '0;
      tick    <= '0;
      selReg  <= '0;
      lenReg  <= '0;
    end else begin
      state   <= stateNext;
      address <= addrNext;
      tick    <= tickNext;
      selReg  <= selNext;
      lenReg  <= lenNext;
    end
  end

  always_comb begin
    stateNext = state;
    addrNext  = address;
    tickNext  = tick;
    selNext   = selReg;
    lenNext   = lenReg;
    if (stop) begin
      stateNext = IDLE;
      addrNext  = '0;
      tickNext  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            selNext   = seq_sel;
            lenNext   = (len > LEN_MAX) ? LEN_MAX : len;
            addrNext  = '0;
            tickNext  = '0;
            stateNext = (len == '0) ? FIN : SHOW;
          end
        end
        SHOW: begin
          if (tick == ON_LAST) begin
            tickNext = '0;
            if (OFF_TICKS > 0) begin
              stateNext = GAP;
            end else if (lastStep) begin
              stateNext = FIN;
            end else begin
              addrNext = address + 1'b1;
            end
          end else begin
            tickNext = tick + 1'b1;
          end
        end
        GAP: begin
          if (tick == OFF_LAST) begin
            tickNext = '0;
            if (lastStep) begin
              stateNext = FIN;
            end else begin
              addrNext  = address + 1'b1;
              stateNext = SHOW;
            end
          end else begin
            tickNext = tick + 1'b1;
          end
        end
        FIN: begin
          stateNext = IDLE;
          addrNext  = '0;
        end
        default: begin
          stateNext = IDLE;
          addrNext  = '0;
          tickNext  = '0;
        end
      endcase
    end
  end

  assign saida = (state == SHOW) ? romColour : '0;
  assign busy  = (state == SHOW) || (state == GAP);
  assign done  = (state == FIN);

endmodule

// File: tb/tb_seq_player.sv
// Randomized self-checking bench for seq_player: a per-cycle expected trace is
// built from the step/tick rules and compared against the DUT outputs.
module tb_seq_player;

  localparam int ON_T  = 8;
  localparam int OFF_T = 2;
  localparam int MAXS  = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic [1:0] seq_sel;
  logic [4:0] len;
  logic [3:0] saida;
  logic [3:0] address;
  logic       busy;
  logic       done;

  int totalChecks = 0;
  int badChecks   = 0;

  typedef struct {
    logic [3:0] saida;
    logic       busy;
    logic       done;
    logic [3:0] addr;
    logic       chkAddr;
  } exp_t;

  exp_t expQ[$];

  logic [3:0] seq0 [16] = '{4'd1, 4'd8, 4'd4, 4'd8, 4'd1, 4'd2, 4'd4, 4'd8,
                            4'd1, 4'd2, 4'd8, 4'd2, 4'd1, 4'd8, 4'd4, 4'd2};
  logic [3:0] seq1 [16] = '{4'd2, 4'd4, 4'd1, 4'd8, 4'd4, 4'd2, 4'd8, 4'd1,
                            4'd2, 4'd1, 4'd4, 4'd8, 4'd1, 4'd4, 4'd2, 4'd8};

  seq_player dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .stop    (stop),
    .seq_sel (seq_sel),
    .len     (len),
    .saida   (saida),
    .address (address),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    totalChecks++;
    if (actual !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [3:0] colourOf(input int sel, input int step);
    return (sel == 0) ? seq0[step] : seq1[step];
  endfunction

  // Expected trace for one playback, first entry = cycle after the start cycle.
  task automatic buildExpected(input int sel, input int ln);
    int n;
    exp_t e;
    expQ.delete();
    n = (ln > MAXS) ? MAXS : ln;
    for (int step = 0; step < n; step++) begin
      for (int i = 0; i < ON_T + OFF_T; i++) begin
        e.saida   = (i < ON_T) ? colourOf(sel, step) : 4'd0;
        e.busy    = 1'b1;
        e.done    = 1'b0;
        e.addr    = 4'(step);
        e.chkAddr = 1'b1;
        expQ.push_back(e);
      end
    end
    e.saida   = 4'd0;
    e.busy    = 1'b0;
    e.done    = 1'b1;
    e.addr    = 4'd0;
    e.chkAddr = 1'b0;
    expQ.push_back(e);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_saida"}, 32'(saida), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_addr"}, 32'(address), 32'd0);
  endtask

  // Called just after a falling edge; returns just after a falling edge.
  task automatic applyStimulus(input int sel, input int ln, input bit hold);
    int n, busyCount, doneCount, maxAddr;
    logic [3:0] lastColour;
    n = (ln > MAXS) ? MAXS : ln;
    busyCount = 0; doneCount = 0; maxAddr = 0; lastColour = 4'd0;
    seq_sel = 2'(sel);
    len     = 5'(ln);
    start   = 1'b1;
    buildExpected(sel, ln);
    foreach (expQ[k]) begin
      @(negedge clk);
      checkOutput("saida", 32'(saida), 32'(expQ[k].saida));
      checkOutput("busy", 32'(busy), 32'(expQ[k].busy));
      checkOutput("done", 32'(done), 32'(expQ[k].done));
      if (expQ[k].chkAddr)
        checkOutput("address", 32'(address), 32'(expQ[k].addr));
      if (busy) busyCount++;
      if (done) doneCount++;
      if (busy && int'(address) > maxAddr) maxAddr = int'(address);
      if (saida != 4'd0) lastColour = saida;
      start = hold && expQ[k].busy;
      if (hold) begin
        seq_sel = 2'($urandom_range(0, 3));
        len     = 5'($urandom);
      end
    end
    @(negedge clk);
    checkIdle("after_fin");
    checkOutput("busy_cycles", 32'(busyCount), 32'(n * (ON_T + OFF_T)));
    checkOutput("done_count", 32'(doneCount), 32'd1);
    if (n > 0) begin
      checkOutput("max_addr", 32'(maxAddr), 32'(n - 1));
      checkOutput("last_colour", 32'(lastColour), 32'(colourOf(sel, n - 1)));
    end
  endtask

  // Plays sequence 0 and raises stop after 'stopAfter' checked cycles.
  task automatic stopTest(input int stopAfter);
    seq_sel = 2'd0; len = 5'd8; start = 1'b1;
    buildExpected(0, 8);
    for (int k = 0; k <= stopAfter; k++) begin
      @(negedge clk);
      checkOutput("pre_stop_saida", 32'(saida), 32'(expQ[k].saida));
      checkOutput("pre_stop_addr", 32'(address), 32'(expQ[k].addr));
      start = 1'b0;
    end
    stop = 1'b1;
    @(negedge clk);
    checkIdle("stop");
    stop = 1'b0;
    @(negedge clk);
    checkIdle("post_stop");
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; seq_sel = 2'd0; len = 5'd0;
    #3;
    checkIdle("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    $display("[TB] basic sequence 0, len 4 (start right after reset release)");
    applyStimulus(0, 4, 1'b0);
    $display("[TB] len 0");
    applyStimulus(1, 0, 1'b0);
    $display("[TB] len 31 clamps to 16 steps");
    applyStimulus(1, 31, 1'b0);
    $display("[TB] start held during playback");
    applyStimulus(0, 3, 1'b1);
    $display("[TB] stop at step 2 mid-show");
    stopTest(22);
    $display("[TB] stop beats simultaneous start");
    start = 1'b1; stop = 1'b1; len = 5'd4;
    @(negedge clk);
    checkIdle("stop_vs_start");
    start = 1'b0; stop = 1'b0;
    $display("[TB] reset mid-gap");
    seq_sel = 2'd0; len = 5'd5; start = 1'b1;
    buildExpected(0, 5);
    for (int k = 0; k <= 18; k++) begin
      @(negedge clk);
      checkOutput("pre_rst_saida", 32'(saida), 32'(expQ[k].saida));
      start = 1'b0;
    end
    checkOutput("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkIdle("async_rst");
    @(negedge clk);
    checkIdle("in_rst");
    rst_n = 1'b1;
    applyStimulus(1, 3, 1'b0);
    $display("[TB] randomized playbacks");
    for (int r = 0; r < 10; r++) begin
      applyStimulus(int'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
                    bit'($urandom_range(0, 1)));
    end
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
